// File: rtl/jogador_automatico.sv
// Automatic player for a memory game. It listens to the game's LED
// presentation, stores the shown sequence and replays it on the buttons
// once the game hands over to the player. In modo2 it also appends one
// generated value after each replay and replays the grown sequence.
// The current FSM state is always visible on db_estado.
module jogador_automatico #(
  parameter int PRESS_CYCLES = 3,
  parameter int GAP_CYCLES   = 2503,
  parameter int MAX_JOGADAS  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       modo2,
  input  logic [3:0] leds,
  input  logic       vez_jogador,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic [4:0] tamanho,
  output logic       ocupado,
  output logic       erro_captura,
  output logic [3:0] db_estado
);

  localparam int MAX_CNT = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [4:0]    MAX_TAM    = 5'(MAX_JOGADAS);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    PREPARA   = 4'd2,
    PRESSIONA = 4'd3,
    INTERVALO = 4'd4,
    GRAVA     = 4'd5,
    ESPERA    = 4'd6,
    FIM       = 4'd7
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    botoes_q, botoes_d;
  logic [4:0]    tamanho_q, tamanho_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [1:0]    g_q, g_d;
  logic          modo2_q, modo2_d;
  logic          erro_q, erro_d;
  logic          first_q, first_d;      // next LED event starts a new presentation
  logic          grava_gap_q, grava_gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    leds_prev_q;

  logic [3:0]    mem [MAX_JOGADAS];
  logic          mem_we;
  logic [3:0]    mem_addr;
  logic [3:0]    mem_wdata;

  logic          led_event;
  logic          leds_onehot;
  logic [4:0]    base_tam;
  logic [4:0]    rd_next;
  logic [3:0]    novo;

  // Next-state, datapath updates and registered button value.
  always_comb begin
    state_d     = state_q;
    botoes_d    = 4'b0000;
    tamanho_d   = tamanho_q;
    rd_ptr_d    = rd_ptr_q;
    g_d         = g_q;
    modo2_d     = modo2_q;
    erro_d      = erro_q;
    first_d     = first_q;
    grava_gap_d = 1'b0;
    cnt_d       = '0;
    mem_we      = 1'b0;
    mem_addr    = tamanho_q[3:0];
    mem_wdata   = leds;
    led_event   = (leds != 4'b0000) && (leds_prev_q == 4'b0000) && !vez_jogador;
    leds_onehot = (leds != 4'b0000) && ((leds & (leds - 4'b0001)) == 4'b0000);
    base_tam    = first_q ? 5'd0 : tamanho_q;
    rd_next     = {1'b0, rd_ptr_q} + 5'd1;
    novo        = 4'b0001 << g_q;

    if (!habilitar) begin
      state_d = OCIOSO;
    end else if ((state_q != OCIOSO) && (ganhou || perdeu)) begin
      state_d = FIM;
    end else begin
      case (state_q)
        OCIOSO: begin
          state_d   = CAPTURA;
          modo2_d   = modo2;
          tamanho_d = 5'd0;
          rd_ptr_d  = 4'd0;
          g_d       = 2'd0;
          erro_d    = 1'b0;
          first_d   = 1'b1;
        end
        CAPTURA: begin
          if (led_event) begin
            first_d = 1'b0;
            if (leds_onehot && (base_tam < MAX_TAM)) begin
              mem_we    = 1'b1;
              mem_addr  = base_tam[3:0];
              mem_wdata = leds;
              tamanho_d = base_tam + 5'd1;
            end else begin
              tamanho_d = base_tam;
              erro_d    = 1'b1;
            end
          end else if (vez_jogador) begin
            if (tamanho_q != 5'd0) begin
              state_d = PREPARA;
            end else begin
              erro_d  = 1'b1;
              state_d = ESPERA;
            end
          end
        end
        PREPARA: begin
          rd_ptr_d = 4'd0;
          if (cnt_q == GAP_LAST) state_d = PRESSIONA;
          else cnt_d = cnt_q + CNT_ONE;
        end
        PRESSIONA: begin
          if (cnt_q == PRESS_LAST) state_d = INTERVALO;
          else cnt_d = cnt_q + CNT_ONE;
        end
        INTERVALO: begin
          if (cnt_q == GAP_LAST) begin
            if (rd_next < tamanho_q) begin
              rd_ptr_d = rd_next[3:0];
              state_d  = PRESSIONA;
            end else if (modo2_q && (tamanho_q < MAX_TAM)) begin
              state_d = GRAVA;
            end else begin
              state_d = ESPERA;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GRAVA: begin
          // Press phase shows the generated value; the value is committed
          // when the press ends, then the trailing gap runs.
          if (!grava_gap_q) begin
            if (cnt_q == PRESS_LAST) begin
              grava_gap_d = 1'b1;
              mem_we      = 1'b1;
              mem_addr    = tamanho_q[3:0];
              mem_wdata   = novo;
              tamanho_d   = tamanho_q + 5'd1;
              g_d         = g_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            if (cnt_q == GAP_LAST) begin
              state_d = ESPERA;
            end else begin
              grava_gap_d = 1'b1;
              cnt_d       = cnt_q + CNT_ONE;
            end
          end
        end
        ESPERA: begin
          if (!vez_jogador) begin
            state_d = CAPTURA;
            first_d = 1'b1;
          end else if (modo2_q) begin
            if (cnt_q == GAP_LAST) state_d = PREPARA;
            else cnt_d = cnt_q + CNT_ONE;
          end
        end
        FIM: begin
          state_d = FIM;
        end
        default: begin
          state_d = OCIOSO;
        end
      endcase
    end

    case (state_d)
      PRESSIONA: botoes_d = mem[rd_ptr_d];
      GRAVA:     botoes_d = grava_gap_d ? 4'b0000 : novo;
      default:   botoes_d = 4'b0000;
    endcase
  end

  // State and datapath registers; reset wins over every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      botoes_q    <= 4'b0000;
      tamanho_q   <= 5'd0;
      rd_ptr_q    <= 4'd0;
      g_q         <= 2'd0;
      modo2_q     <= 1'b0;
      erro_q      <= 1'b0;
      first_q     <= 1'b0;
      grava_gap_q <= 1'b0;
      cnt_q       <= '0;
      leds_prev_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      botoes_q    <= botoes_d;
      tamanho_q   <= tamanho_d;
      rd_ptr_q    <= rd_ptr_d;
      g_q         <= g_d;
      modo2_q     <= modo2_d;
      erro_q      <= erro_d;
      first_q     <= first_d;
      grava_gap_q <= grava_gap_d;
      cnt_q       <= cnt_d;
      leds_prev_q <= leds;
    end
  end

  // Sequence memory; contents are not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign botoes       = botoes_q;
  assign tamanho      = tamanho_q;
  assign erro_captura = erro_q;
  assign db_estado    = state_q;
  assign ocupado      = (state_q != OCIOSO) && (state_q != FIM);

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter PRESS_CYCLES, default 3: cycles each button value is held on botoes.
REQ-002 Parameter GAP_CYCLES, default 2503: idle cycles (botoes=0000) before/after each press.
REQ-003 Parameter MAX_JOGADAS, default 16: sequence memory depth.
REQ-004 clock  in  1  single system clock, all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 habilitar  in  1  enables the automatic player; 0 forces OCIOSO.
REQ-007 modo2  in  1  sampled on OCIOSO exit; 1 = append one new value after each replay.
REQ-008 leds  in  4  game presentation LEDs, one-hot or 0000.
REQ-009 vez_jogador  in  1  game awaits player input.
REQ-010 ganhou, perdeu  in  1 each  game end flags.
REQ-011 botoes  out  4  registered one-hot button drive to the game.
REQ-012 tamanho  out  5  number of valid stored values (0..16).
REQ-013 ocupado  out  1  high in any state except OCIOSO and FIM.
REQ-014 erro_captura  out  1  sticky capture error flag.
REQ-015 db_estado  out  4  current state encoding.

Function
REQ-016 States/encoding: OCIOSO=0, CAPTURA=1, PREPARA=2, PRESSIONA=3, INTERVALO=4, GRAVA=5, ESPERA=6, FIM=7.
REQ-017 OCIOSO -> CAPTURA when habilitar=1; modo2 latched that cycle; tamanho, write pointer, generator cleared.
REQ-018 CAPTURA: rising LED event = leds!=0000 while previous-cycle leds==0000 and vez_jogador=0.
REQ-019 First LED event after entering CAPTURA resets write pointer and tamanho to 0 before storing (new presentation overwrites, modo1 semantics).
REQ-020 One-hot event: store leds at write pointer, tamanho+1 in same cycle.
REQ-021 Non-one-hot event, or event with tamanho=MAX_JOGADAS: value discarded, erro_captura<=1.
REQ-022 CAPTURA -> PREPARA when vez_jogador=1 and tamanho>0; with tamanho=0 -> erro_captura<=1, go ESPERA.
REQ-023 PREPARA: botoes=0000 for GAP_CYCLES, read pointer=0, then PRESSIONA.
REQ-024 PRESSIONA: botoes=mem[read pointer] for exactly PRESS_CYCLES cycles, then INTERVALO.
REQ-025 INTERVALO: botoes=0000 for GAP_CYCLES; read pointer+1; if read pointer+1<tamanho -> PRESSIONA, else GRAVA if modo2=1 and tamanho<MAX_JOGADAS, else ESPERA.
REQ-026 Generator: 2-bit counter g, reset 0; new value = one-hot 1<<g (0001,0010,0100,1000, repeating); g+1 per append.
REQ-027 GRAVA: botoes=new value for PRESS_CYCLES, value written at index tamanho, tamanho+1, then GAP_CYCLES of 0000, then ESPERA.
REQ-028 ESPERA: vez_jogador=0 -> CAPTURA; modo2=1 and vez_jogador=1 for GAP_CYCLES consecutive cycles -> PREPARA (replay grown sequence); modo1 with vez_jogador=1 stays.
REQ-029 ganhou=1 or perdeu=1 in any non-OCIOSO state -> FIM next cycle, botoes<=0000 immediately (press truncated).
REQ-030 FIM holds, memory and tamanho retained; habilitar=0 -> OCIOSO.
REQ-031 habilitar=0 in any state -> OCIOSO next cycle, botoes=0000; erro_captura cleared only on OCIOSO->CAPTURA or reset.
REQ-032 botoes is never non-zero for two different values without >=1 intervening 0000 cycle; never non-one-hot.
REQ-033 Timing counters sized for max(PRESS_CYCLES, GAP_CYCLES); pointers 4 bits, tamanho 5 bits, no wrap.

Reset
REQ-034 reset=1 on a rising edge: state OCIOSO, botoes=0000, tamanho=0, ocupado=0, erro_captura=0, db_estado=0000, g=0, pointers=0; memory contents undefined.
REQ-035 Reset mid-press drops botoes to 0000 on the same edge; reset has priority over all inputs.

Verification (PRESS_CYCLES=3, GAP_CYCLES=4)
REQ-036 modo1: present leds 0100 then 0001 (each 5 cycles, 0000 between), raise vez_jogador -> tamanho=2, 4 cycles 0000, botoes 0100 x3, 0000 x4, 0001 x3, 0000, state ESPERA.
REQ-037 modo2: present 1000, vez_jogador=1 held -> botoes 1000 x3, gap, 0001 x3 (generated), tamanho=2; after 4 more gap cycles replays 1000,0001 then appends 0010, tamanho=3.
REQ-038 leds=0110 during CAPTURA -> erro_captura=1, tamanho unchanged; 17 one-hot events -> tamanho=16, erro_captura=1.
REQ-039 perdeu=1 during 2nd cycle of a press -> botoes=0000 next cycle, db_estado=7, ocupado=0; habilitar=0 -> db_estado=0.
REQ-040 reset asserted in INTERVALO with tamanho=5 -> next cycle all outputs at REQ-034 values; habilitar=1 restarts at CAPTURA.
